l2_mem_arbiter: RTL

L2_MEM_ARBITER -- requirements
Module: l2_mem_arbiter

---
 rtl/l2_mem_arbiter_pkg.sv | 13 +
 rtl/l2_mem_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/l2_mem_arbiter_pkg.sv
// rtl/l2_mem_arbiter_pkg.sv - shared state encodings and widths for the L2 memory arbiter
package l2_mem_arbiter_pkg;

    localparam int LINE_W  = 128;
    localparam int LADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - I/D L2 request arbiter onto one slow memory port (ARB_ROUND_ROBIN_EN selects round-robin, else D-side fixed priority)
module l2_mem_arbiter
    import l2_mem_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               proc_reset,
    input  logic               i_read,
    input  logic               i_write,
    input  logic [LADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0]  i_wdata,
    output logic [LINE_W-1:0]  i_rdata,
    output logic               i_ready,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [LADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0]  d_wdata,
    output logic [LINE_W-1:0]  d_rdata,
    output logic               d_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               grant_d
);

    arb_state_e         state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [LADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               i_pend, d_pend, pick_d;

    assign i_pend = i_read | i_write;
    assign d_pend = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the D-side should win the next tie (it was not granted last)
    logic rr_d_next_q, rr_d_next_d;

    assign pick_d = d_pend & (~i_pend | rr_d_next_q);
`else
    assign pick_d = d_pend;
`endif

    // Next-state and capture: the winner's op/addr/wdata are latched only at grant time
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d_next_d = rr_d_next_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_pend | d_pend) begin
                    state_d = pick_d ? GNT_D : GNT_I;
                    // read+write together counts as a write
                    op_wr_d = pick_d ? d_write : i_write;
                    addr_d  = pick_d ? d_addr  : i_addr;
                    wdata_d = pick_d ? d_wdata : i_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_d_next_d = ~pick_d;
`endif
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d_next_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d_next_q <= rr_d_next_d;
`endif
        end
    end

    // Memory port and completion outputs driven purely from the captured transaction
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        grant_d   = 1'b0;
        if (state_q == GNT_I || state_q == GNT_D) begin
            mem_read  = ~op_wr_q;
            mem_write = op_wr_q;
        end
        if (state_q == GNT_I) begin
            i_ready = mem_ready;
        end
        if (state_q == GNT_D) begin
            d_ready = mem_ready;
            grant_d = 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
